fifo_pixel_reader: RTL and testbench

Read-side consumer for the 8-bit pixel FIFO in the image-processing accelerator. It drains one frame of `IMG_WIDTH x IMG_HEIGHT` pixels from the FIFO read port (`rd` / `fifo_empty` / `data_out`) and presents them as a valid/ready stream with line and frame markers to the downstream processing stage. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so back-pressure never loses or duplicates a pixel.

---
 rtl/fifo_pixel_reader.sv | 124 ++++++++++++
 tb/tb_fifo_pixel_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pixel_reader.sv
// Drains one IMG_WIDTH x IMG_HEIGHT frame from a pixel FIFO into a valid/ready
// stream with line/frame markers; a 2-entry buffer hides the FIFO read latency.
module fifo_pixel_reader #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              rd,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              m_sol,
  output logic              m_eol
);
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int RW   = $clog2(NPIX + 1);
  localparam int XW   = $clog2(IMG_WIDTH);
  localparam int YW   = $clog2(IMG_HEIGHT);
  localparam logic [RW-1:0] REQ_MAX = RW'(NPIX);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [RW-1:0]     req_cnt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              rd_q;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] buf0, buf1;
  logic              pop;
  logic [2:0]        occ;

  assign pop = m_valid && m_ready;
  // Occupancy after this cycle counting the read already in flight; issuing a
  // new read only while it is below 2 means the buffer can never overflow.
  assign occ = {1'b0, cnt} + {2'b0, rd_q} - {2'b0, pop};
  assign rd  = !rst && (state == RUN) && !fifo_empty && (req_cnt < REQ_MAX) && (occ < 3'd2);

  assign m_valid = (cnt != 2'd0);
  assign m_data  = buf0;
  assign m_sol   = m_valid && (x == '0);
  assign m_eol   = m_valid && (x == X_LAST);
  assign m_sof   = m_valid && (x == '0) && (y == '0);
  assign m_eof   = m_valid && (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      req_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      rd_q       <= 1'b0;
      cnt        <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
    end else begin
      rd_q <= rd;
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          req_cnt <= '0;
          x       <= '0;
          y       <= '0;
        end
        RUN: begin
          if (rd) req_cnt <= req_cnt + 1'b1;
          if (pop) begin
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
              if (y == Y_LAST) begin
                state      <= DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // buf0 is always the head; a simultaneous push/pop shifts through it
      case ({rd_q, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= data_out;
          else             buf1 <= data_out;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) buf0 <= data_out;
          else begin
            buf0 <= buf1;
            buf1 <= data_out;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Bench for fifo_pixel_reader: 4x2 frame, FIFO modelled as a queue, per-cycle
// scoreboard on pixel order, markers, stalls, read credit and frame_done.
module tb_fifo_pixel_reader;
  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, frame_done, rd;
  logic       fifo_empty = 1'b1;
  logic [7:0] data_out = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_sof, m_eof, m_sol, m_eol;

  fifo_pixel_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .rd(rd), .fifo_empty(fifo_empty), .data_out(data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eof(m_eof), .m_sol(m_sol), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model and feed control
  logic [7:0] q[$];
  logic [7:0] pix_next = 8'h00;
  int feed_mode = 0, feed_n = 3, feed_left = 0, cyc = 0;

  // scoreboard state
  logic [7:0] rd_hist[$];
  int  hs_k = 0, reads = 0;
  bit  busy_exp = 0, fd_exp = 0, stall_prev = 0;
  logic [7:0] prev_data, first_pix;
  logic [3:0] prev_marks;

  typedef struct {
    logic       start;
    logic       ready;
    logic [2:0] ctl;   // {busy, rd, m_valid}
    logic [7:0] data;
    logic [3:0] mk;    // {sof, eof, sol, eol}
    logic       fd;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    logic rd_s;
    rd_s = rd;
    @(posedge clk); #1;
    if (rd_s) begin
      if (q.size() == 0) fail("fifo_underflow");
      else data_out = q.pop_front();
    end
    if (feed_left > 0 && ((feed_mode == 1 && cyc % feed_n == 0) ||
                          (feed_mode == 2 && $urandom_range(0, 2) != 0))) begin
      q.push_back(pix_next);
      pix_next++;
      feed_left--;
    end
    fifo_empty = (q.size() == 0);
    cyc++;
  endtask

  task automatic mon();
    bit pop_now, fd_n, acc;
    int k;
    logic [7:0] e;
    if (rst) begin
      chk("rd_in_reset", rd, 0);
      hs_k = 0; reads = 0; rd_hist.delete();
      busy_exp = 0; fd_exp = 0; stall_prev = 0;
      return;
    end
    chk("busy", busy, busy_exp);
    chk("frame_done", frame_done, fd_exp);
    if (fifo_empty) chk("rd_when_empty", rd, 0);
    if (stall_prev) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_marks", {m_sof, m_eof, m_sol, m_eol}, prev_marks);
    end
    pop_now = m_valid && m_ready;
    fd_n = 0;
    if (pop_now) begin
      k = hs_k;
      if (rd_hist.size() == 0) fail("bubble_pixel");
      else begin
        e = rd_hist.pop_front();
        chk("pixel", m_data, e);
      end
      chk("marks", {m_sof, m_eof, m_sol, m_eol},
          {k == 0, k == NPIX - 1, (k % W) == 0, (k % W) == W - 1});
      if (k == 0) first_pix = m_data;
      hs_k++;
      fd_n = (k == NPIX - 1);
    end
    if (rd) begin
      reads++;
      if (q.size() > 0) rd_hist.push_back(q[0]);
      chk("reads_le_frame", reads <= NPIX, 1);
      chk("outstanding_le_2", (reads - hs_k) <= 2, 1);
    end
    stall_prev = m_valid && !m_ready;
    prev_data  = m_data;
    prev_marks = {m_sof, m_eof, m_sol, m_eol};
    acc = start && !busy_exp && !fd_exp;
    fd_exp = fd_n;
    busy_exp = fd_n ? 1'b0 : (acc ? 1'b1 : busy_exp);
    if (acc) begin
      hs_k = 0; reads = 0; rd_hist.delete();
    end
  endtask

  task automatic check_idle();
    chk("idle_busy", busy, 0);
    chk("idle_frame_done", frame_done, 0);
    chk("idle_rd", rd, 0);
    chk("idle_valid", m_valid, 0);
    chk("idle_data", m_data, 0);
    chk("idle_marks", {m_sof, m_eof, m_sol, m_eol}, 0);
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
    fifo_empty = (q.size() == 0);
  endtask

  // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random
  task automatic run_frame(input int rmode, input bit stray, input int stop_hs);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      start = (n == 0) || (stray && n == 4) ||
              (rmode == 2 && stray && $urandom_range(0, 15) == 0);
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (n % 4 == 0) || (n % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      seen = frame_done;
      mon();
      tick();
      if (stop_hs >= 0 && hs_k >= stop_hs) seen = 1;
      n++;
    end
    start = 1'b0;
    if (!seen) begin
      fail("frame_timeout");
      rst = 1'b1;
      #1; mon(); tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b1, 3'b000, 8'h00, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b110, 8'h00, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b110, 8'h00, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b111, 8'h10, 4'b1010, 1'b0},
      '{1'b0, 1'b1, 3'b111, 8'h11, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b111, 8'h12, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b111, 8'h13, 4'b0001, 1'b0},
      '{1'b0, 1'b1, 3'b111, 8'h14, 4'b0010, 1'b0},
      '{1'b0, 1'b1, 3'b111, 8'h15, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b101, 8'h16, 4'b0000, 1'b0},
      '{1'b0, 1'b1, 3'b101, 8'h17, 4'b0101, 1'b0},
      '{1'b0, 1'b1, 3'b000, 8'h00, 4'b0000, 1'b1},
      '{1'b0, 1'b1, 3'b000, 8'h00, 4'b0000, 1'b0}
    };

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle();
    mon();
    tick();

    // 4x2 frame at full rate, cycle-exact
    preload(8'h10, 8);
    for (int i = 0; i < 13; i++) begin
      start   = tbl[i].start;
      m_ready = tbl[i].ready;
      #1;
      chk("tbl_busy", busy, tbl[i].ctl[2]);
      chk("tbl_rd", rd, tbl[i].ctl[1]);
      chk("tbl_valid", m_valid, tbl[i].ctl[0]);
      if (tbl[i].ctl[0]) chk("tbl_data", m_data, tbl[i].data);
      chk("tbl_marks", {m_sof, m_eof, m_sol, m_eol}, tbl[i].mk);
      chk("tbl_frame_done", frame_done, tbl[i].fd);
      mon();
      tick();
    end
    start = 1'b0;

    // back-pressure pattern 1,0,0,1
    q.delete();
    preload(8'h20, 8);
    run_frame(1, 0, -1);
    chk("bp_count", hs_k, NPIX);

    // FIFO starts empty, one pixel every 3 cycles
    q.delete();
    fifo_empty = 1'b1;
    pix_next = 8'h30; feed_mode = 1; feed_n = 3; feed_left = 8;
    run_frame(0, 0, -1);
    chk("slow_count", hs_k, NPIX);
    feed_mode = 0; feed_left = 0;

    // surplus FIFO data stays for the next frame
    q.delete();
    preload(8'h40, 12);
    run_frame(0, 0, -1);
    chk("surplus_reads", reads, NPIX);
    chk("surplus_left", q.size(), 4);
    preload(8'h4C, 4);
    run_frame(0, 0, -1);
    chk("surplus_next_sof_pix", first_pix, 8'h48);

    // reset after 5 handshakes
    q.delete();
    preload(8'h50, 8);
    run_frame(0, 0, 5);
    chk("rst_hs_before", hs_k, 5);
    rst = 1'b1;
    #1; mon(); tick();
    rst = 1'b0;
    #1;
    check_idle();
    mon();
    tick();
    q.delete();
    preload(8'h58, 8);
    run_frame(0, 0, -1);
    chk("rst_restart_pix", first_pix, 8'h58);
    chk("rst_restart_count", hs_k, NPIX);

    // stray start mid-frame
    q.delete();
    preload(8'h60, 8);
    run_frame(0, 1, -1);
    chk("stray_count", hs_k, NPIX);
    chk("stray_reads", reads, NPIX);

    // randomized: random feed, ready and stray starts
    pix_next = 8'h80; feed_mode = 2;
    for (int f = 0; f < 20; f++) begin
      feed_left = 1000;
      run_frame(2, 1, -1);
      chk("rand_count", hs_k, NPIX);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
